// File: rtl/seg_display_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scheduler_if
// Purpose  : Source-side buses and scan-driver outputs of the display scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_display_scheduler_if;
  logic [23:0] bg_data;
  logic [5:0]  bg_en;
  logic [5:0]  bg_dot;
  logic        fg_req;
  logic [23:0] fg_data;
  logic [5:0]  fg_en;
  logic [5:0]  fg_dot;
  logic [15:0] fg_hold_ms;
  logic        fg_blink;
  logic        fg_ack;
  logic        fg_active;
  logic [3:0]  seg_data_1;
  logic [3:0]  seg_data_2;
  logic [3:0]  seg_data_3;
  logic [3:0]  seg_data_4;
  logic [3:0]  seg_data_5;
  logic [3:0]  seg_data_6;
  logic [5:0]  seg_data_en;
  logic [5:0]  seg_dot_en;

  modport master (
    output bg_data, bg_en, bg_dot,
    output fg_req, fg_data, fg_en, fg_dot, fg_hold_ms, fg_blink,
    input  fg_ack, fg_active,
    input  seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5, seg_data_6,
    input  seg_data_en, seg_dot_en
  );

  modport slave (
    input  bg_data, bg_en, bg_dot,
    input  fg_req, fg_data, fg_en, fg_dot, fg_hold_ms, fg_blink,
    output fg_ack, fg_active,
    output seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5, seg_data_6,
    output seg_data_en, seg_dot_en
  );
endinterface
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scheduler
// Purpose  : Chooses background or held/blinking foreground message for the
//            6-digit scan driver, with invalid-digit blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scheduler #(
  parameter int TICK_DIV = 12000,
  parameter int HOLD_MS  = 2000,
  parameter int BLINK_MS = 250
) (
  input  wire                    clk_in,
  input  wire                    rst_n_in,
  seg_display_scheduler_if.slave bus
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [TICK_W-1:0]  c_tick_last    = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] c_blink_last   = BLINK_W'(BLINK_MS - 1);
  localparam logic [15:0]        c_hold_default = 16'(HOLD_MS);

  typedef enum logic [0:0] {
    ST_BG   = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [15:0]        r_hold_cnt;
  logic [15:0]        w_hold_nx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [BLINK_W-1:0] w_blink_cnt_nx;
  logic               r_phase_on;
  logic               w_phase_on_nx;
  logic               r_ack;
  logic               r_active;

  logic [23:0]        r_sh_data;
  logic [5:0]         r_sh_en;
  logic [5:0]         r_sh_dot;
  logic               r_sh_blink;

  logic [23:0]        r_seg_data;
  logic [5:0]         r_seg_en;
  logic [5:0]         r_seg_dot;

  logic               w_tick;
  logic               w_capture;
  logic [15:0]        w_hold_sel;
  logic [23:0]        w_src_data;
  logic [5:0]         w_src_en;
  logic [5:0]         w_src_dot;
  logic               w_src_blink;
  logic               w_blank;
  logic [5:0]         w_digit_ok;

  assign w_tick     = (r_tick_cnt == c_tick_last);
  assign w_capture  = bus.fg_req && !r_ack;
  assign w_hold_sel = (bus.fg_hold_ms == 16'd0) ? c_hold_default : bus.fg_hold_ms;

  // Next timing state; a capture overrides any tick arriving in the same cycle.
  always_comb begin
    w_state_nx     = r_state;
    w_hold_nx      = r_hold_cnt;
    w_blink_cnt_nx = r_blink_cnt;
    w_phase_on_nx  = r_phase_on;
    if (w_capture) begin
      w_state_nx     = ST_SHOW;
      w_hold_nx      = w_hold_sel;
      w_blink_cnt_nx = '0;
      w_phase_on_nx  = 1'b1;
    end else if ((r_state == ST_SHOW) && w_tick) begin
      w_hold_nx = r_hold_cnt - 16'd1;
      if (r_hold_cnt == 16'd1) begin
        w_state_nx = ST_BG;
      end
      if (r_blink_cnt == c_blink_last) begin
        w_blink_cnt_nx = '0;
        w_phase_on_nx  = ~r_phase_on;
      end else begin
        w_blink_cnt_nx = r_blink_cnt + 1'b1;
      end
    end
  end

  // Source for the next displayed frame, taken from the next state so the
  // display and fg_active change on the same edge.
  always_comb begin
    w_src_data  = bus.bg_data;
    w_src_en    = bus.bg_en;
    w_src_dot   = bus.bg_dot;
    w_src_blink = 1'b0;
    if (w_capture) begin
      w_src_data  = bus.fg_data;
      w_src_en    = bus.fg_en;
      w_src_dot   = bus.fg_dot;
      w_src_blink = bus.fg_blink;
    end else if (w_state_nx == ST_SHOW) begin
      w_src_data  = r_sh_data;
      w_src_en    = r_sh_en;
      w_src_dot   = r_sh_dot;
      w_src_blink = r_sh_blink;
    end
  end

  assign w_blank = w_src_blink && !w_phase_on_nx;

  for (genvar k = 0; k < 6; k++) begin : g_digit
    assign w_digit_ok[k] = (w_src_data[4*k +: 4] <= 4'd9);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_BG;
      r_tick_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
      r_ack       <= 1'b0;
      r_active    <= 1'b0;
      r_sh_data   <= '0;
      r_sh_en     <= '0;
      r_sh_dot    <= '0;
      r_sh_blink  <= 1'b0;
      r_seg_data  <= '0;
      r_seg_en    <= '0;
      r_seg_dot   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_hold_cnt  <= w_hold_nx;
      r_blink_cnt <= w_blink_cnt_nx;
      r_phase_on  <= w_phase_on_nx;
      r_ack       <= w_capture;
      r_active    <= (w_state_nx == ST_SHOW);

      if (w_capture || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

      if (w_capture) begin
        r_sh_data  <= bus.fg_data;
        r_sh_en    <= bus.fg_en;
        r_sh_dot   <= bus.fg_dot;
        r_sh_blink <= bus.fg_blink;
      end

      // Codes always pass through; only the enables are blanked.
      r_seg_data <= w_src_data;
      r_seg_en   <= w_src_en & w_digit_ok & {6{~w_blank}};
      r_seg_dot  <= w_src_dot & {6{~w_blank}};
    end
  end

  assign bus.fg_ack      = r_ack;
  assign bus.fg_active   = r_active;
  assign bus.seg_data_1  = r_seg_data[3:0];
  assign bus.seg_data_2  = r_seg_data[7:4];
  assign bus.seg_data_3  = r_seg_data[11:8];
  assign bus.seg_data_4  = r_seg_data[15:12];
  assign bus.seg_data_5  = r_seg_data[19:16];
  assign bus.seg_data_6  = r_seg_data[23:20];
  assign bus.seg_data_en = r_seg_en;
  assign bus.seg_dot_en  = r_seg_dot;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scheduler
// Purpose  : Directed + random stimulus against an elapsed-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scheduler;

  localparam int TICK_DIV = 4;
  localparam int HOLD_MS  = 3;
  localparam int BLINK_MS = 2;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b1;

  seg_display_scheduler_if bus ();

  seg_display_scheduler #(
    .TICK_DIV (TICK_DIV),
    .HOLD_MS  (HOLD_MS),
    .BLINK_MS (BLINK_MS)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: foreground described by cycles elapsed since capture.
  bit          m_ack;
  bit          m_fg;
  int          m_c;
  int          m_hold;
  logic [23:0] m_data;
  logic [5:0]  m_en;
  logic [5:0]  m_dot;
  bit          m_blink;
  logic [23:0] e_data;
  logic [5:0]  e_en;
  logic [5:0]  e_dot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] obs_data();
    return {bus.seg_data_6, bus.seg_data_5, bus.seg_data_4,
            bus.seg_data_3, bus.seg_data_2, bus.seg_data_1};
  endfunction

  task automatic model_reset();
    m_ack = 0; m_fg = 0; m_c = 0; m_hold = 0; m_blink = 0;
    m_data = '0; m_en = '0; m_dot = '0;
    e_data = '0; e_en = '0; e_dot = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ack"},    32'(bus.fg_ack),      32'(m_ack));
    check({tag, ".active"}, 32'(bus.fg_active),   32'(m_fg));
    check({tag, ".data"},   32'(obs_data()),      32'(e_data));
    check({tag, ".en"},     32'(bus.seg_data_en), 32'(e_en));
    check({tag, ".dot"},    32'(bus.seg_dot_en),  32'(e_dot));
  endtask

  // One clock: model consumes the inputs present at the edge, then compare.
  task automatic step(input string tag);
    bit          cap;
    bit          blank;
    logic [23:0] sd;
    logic [5:0]  se;
    logic [5:0]  sdot;
    @(posedge clk_in);
    cap = bus.fg_req && !m_ack;
    m_ack = cap;
    if (cap) begin
      m_data  = bus.fg_data;
      m_en    = bus.fg_en;
      m_dot   = bus.fg_dot;
      m_blink = bus.fg_blink;
      m_hold  = (bus.fg_hold_ms == 0) ? HOLD_MS : int'(bus.fg_hold_ms);
      m_fg    = 1;
      m_c     = 1;
    end else if (m_fg) begin
      m_c++;
      if (m_c > m_hold * TICK_DIV) m_fg = 0;
    end
    if (m_fg) begin
      sd = m_data; se = m_en; sdot = m_dot;
      blank = m_blink && ((((m_c - 1) / (BLINK_MS * TICK_DIV)) % 2) == 1);
    end else begin
      sd = bus.bg_data; se = bus.bg_en; sdot = bus.bg_dot;
      blank = 0;
    end
    e_data = sd;
    for (int k = 0; k < 6; k++) begin
      e_en[k]  = se[k] && (sd[4*k +: 4] <= 4'd9) && !blank;
      e_dot[k] = sdot[k] && !blank;
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_fg(input logic [23:0] d, input logic [5:0] en, input logic [5:0] dot,
                        input logic [15:0] hold, input logic blink);
    bus.fg_data = d; bus.fg_en = en; bus.fg_dot = dot;
    bus.fg_hold_ms = hold; bus.fg_blink = blink;
  endtask

  initial begin
    int cnt;
    int off_cnt;
    model_reset();
    bus.bg_data = '0; bus.bg_en = '0; bus.bg_dot = '0;
    bus.fg_req = 0;
    set_fg('0, '0, '0, '0, 0);

    // Reset values
    #1 rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_all("reset");
    rst_n_in = 1'b1;

    // Background pass-through
    bus.bg_data = 24'h543210; bus.bg_en = 6'h3F; bus.bg_dot = 6'h01;
    step("bg");
    check("bg.digit6", 32'(bus.seg_data_6), 32'd5);
    step("bg2");

    // Default-hold foreground for 12 cycles
    set_fg(24'h999999, 6'h3F, 6'h00, 16'd0, 0);
    bus.fg_req = 1;
    step("fg_default");
    bus.fg_req = 0;
    cnt = int'(bus.fg_active);
    for (int i = 0; i < 14; i++) begin
      step("fg_default");
      cnt += int'(bus.fg_active);
    end
    check("fg_default.len", 32'(cnt), 32'd12);

    // Blinking foreground, hold 5 ticks
    set_fg(24'h123456, 6'h3F, 6'h3F, 16'd5, 1);
    bus.fg_req = 1;
    step("blink");
    bus.fg_req = 0;
    cnt = 1; off_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      step("blink");
      cnt += int'(bus.fg_active);
      if (bus.fg_active && bus.seg_data_en == 6'h00) off_cnt++;
    end
    check("blink.len", 32'(cnt), 32'd20);
    check("blink.off", 32'(off_cnt), 32'd8);

    // Pre-emption 6 cycles into a show
    set_fg(24'h999999, 6'h3F, 6'h00, 16'd0, 0);
    bus.fg_req = 1;
    step("preempt");
    bus.fg_req = 0;
    repeat (5) step("preempt");
    set_fg(24'h111111, 6'h3F, 6'h00, 16'd0, 0);
    bus.fg_req = 1;
    step("preempt2");
    bus.fg_req = 0;
    check("preempt.digits", 32'(obs_data()), 32'h111111);
    repeat (14) step("preempt2");

    // Invalid digit blanking
    bus.bg_data = 24'h00000A; bus.bg_en = 6'h3F; bus.bg_dot = 6'h00;
    repeat (2) step("invalid");

    // Held request: recapture every other cycle, then reset mid-show
    bus.fg_req = 1;
    for (int i = 0; i < 6; i++) begin
      set_fg(24'($urandom) & 24'h777777, 6'h3F, 6'($urandom), 16'd0, 0);
      step("held");
    end
    bus.fg_req = 0;
    repeat (3) step("held_show");
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bus.bg_data = 24'($urandom);
      bus.bg_en   = 6'($urandom);
      bus.bg_dot  = 6'($urandom);
      if (bus.fg_req && bus.fg_ack) begin
        bus.fg_req = 0;
      end else if (!bus.fg_req && $urandom_range(0, 9) == 0) begin
        set_fg(24'($urandom), 6'($urandom), 6'($urandom),
               16'($urandom_range(0, 3)), 1'($urandom));
        bus.fg_req = 1;
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
